// File: rtl/dino_pkg.sv
// Shared constants for the 30-bit game LFSR and the stream checker state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dino_pkg;

  localparam int LFSR_W = 30;

  // Feedback taps of the game LFSR: next = sr[29]^sr[5]^sr[3]^sr[0]
  localparam int TAP_A = 29;
  localparam int TAP_B = 5;
  localparam int TAP_C = 3;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 30'h20000029;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr30_step.sv
// Combinational next-bit function of the 30-bit game LFSR.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module lfsr30_step
  import dino_pkg::*;
(
  input  logic [LFSR_W-1:0] sr_i,
  output logic              next_bit_o
);

  assign next_bit_o = sr_i[TAP_A] ^ sr_i[TAP_B] ^ sr_i[TAP_C] ^ sr_i[TAP_D];

endmodule

// File: rtl/lfsr_checker.sv
// Locks onto a received game-LFSR bit stream and counts prediction mismatches while locked.
// Latency: locked/err_pulse/err_count update one cycle after the qualifying valid bit.
// Backpressure: none; all state holds while bit_valid is low. Optional LFSR_CHECKER_FLYWHEEL_EN
// makes the locked shadow register free-run on its own prediction.
module lfsr_checker
  import dino_pkg::*;
#(
  parameter int LOCK_CNT    = 32,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  localparam int FILL_W  = $clog2(LFSR_W);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int ERR_W   = $clog2(LOSS_THRESH + 1);

  chk_state_e          state_q, state_d;
  logic [LFSR_W-1:0]   sr_q, sr_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]    win_err_q, win_err_d;
  logic [15:0]         err_count_q, err_count_d;
  logic                err_pulse_q, err_pulse_d;
  logic                locked_q, locked_d;

  logic                pred_bit;
  logic                mismatch;
  logic                lock_shift_bit;
  logic                sr_zero;

  lfsr30_step u_step (
    .sr_i       (sr_q),
    .next_bit_o (pred_bit)
  );

  assign mismatch = (bit_in != pred_bit);
  assign sr_zero  = (sr_q == '0);

`ifdef LFSR_CHECKER_FLYWHEEL_EN
  // Flywheel: a corrupted input bit never enters the shadow register, so it costs one error.
  assign lock_shift_bit = pred_bit;
`else
  // Tracking: the received bit is shifted in, so a flip is re-seen at each later tap.
  assign lock_shift_bit = bit_in;
`endif

  // Next-state and counter logic; everything holds unless a valid bit is present.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_cnt_d  = fill_cnt_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (bit_valid) begin
      case (state_q)
        ST_FILL: begin
          sr_d = {sr_q[LFSR_W-2:0], bit_in};
          if (fill_cnt_q == FILL_W'(LFSR_W - 1)) begin
            state_d    = ST_HUNT;
            fill_cnt_d = '0;
            match_d    = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
          end
        end

        ST_HUNT: begin
          sr_d = {sr_q[LFSR_W-2:0], bit_in};
          // An all-zero register predicts zeros forever; refuse to count that as a match.
          if (sr_zero || mismatch) begin
            match_d = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d   = ST_LOCKED;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end

        ST_LOCKED: begin
          sr_d = {sr_q[LFSR_W-2:0], lock_shift_bit};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end
          end
          // An error on the wrapping bit opens the new window's tally.
          if (win_cnt_q == WIN_W'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            win_err_d = ERR_W'(mismatch);
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_q + ERR_W'(mismatch);
          end
          if (win_err_d >= ERR_W'(LOSS_THRESH)) begin
            state_d    = ST_FILL;
            fill_cnt_d = '0;
          end
        end

        default: begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset taking priority over valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      sr_q        <= '0;
      fill_cnt_q  <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: per-bit expectations queued by stimulus, popped by a monitor.
// Latency: expects outputs one cycle after each sampled valid bit.
// Backpressure: none; bit_valid may be gapped.
module tb_lfsr_checker;
  import dino_pkg::*;

  logic        clk;
  logic        rst;
  logic        bit_valid;
  logic        bit_in;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   idx;
    logic exp_locked;
    logic exp_pulse;
  } exp_t;

  exp_t sb_q[$];
  logic mon_vld;

  lfsr_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s idx=%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Note which edges consumed a valid bit so the monitor knows when an answer is due.
  always @(posedge clk) mon_vld <= bit_valid && !rst;

  // Monitor: one expectation is consumed per sampled valid bit.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_vld === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: output with no queued expectation at %0t", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("locked", e.idx, {31'd0, locked}, {31'd0, e.exp_locked});
          chk("err_pulse", e.idx, {31'd0, err_pulse}, {31'd0, e.exp_pulse});
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic bit in_list(input int k, input int lst[5]);
    for (int i = 0; i < 5; i++) if (lst[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // Drives n valid bits from the seeded generator (or zeros), inverting the listed indices.
  // Expected lock: high from bit 61 on, except bits off_at..relock_at-1.
  task automatic run_stream(input int n, input int gap, input bit zeros, input int flips[5],
                            input int pulses[5], input int off_at, input int relock_at);
    logic [LFSR_W-1:0] gen;
    logic              fb;
    exp_t              e;
    gen = LFSR_SEED;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
      end
      fb  = gen[29] ^ gen[5] ^ gen[3] ^ gen[0];
      gen = {gen[28:0], fb};
      @(posedge clk);
      #1;
      bit_valid = 1'b1;
      bit_in    = zeros ? 1'b0 : (fb ^ in_list(k, flips));
      e.idx        = k;
      e.exp_locked = !zeros && (k >= 61) && !(k >= off_at && k < relock_at);
      e.exp_pulse  = in_list(k, pulses);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", n, sb_q.size(), 0);
  endtask

  initial begin
    int fl[5];
    int pl[5];
    int none[5];
    none      = '{-1, -1, -1, -1, -1};
    rst       = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_locked", 0, {31'd0, locked}, 0);
    chk("rst_err_pulse", 0, {31'd0, err_pulse}, 0);
    chk("rst_err_count", 0, {16'd0, err_count}, 0);

    // Single flipped bit at 200 inside the locked stream.
    fl = '{200, -1, -1, -1, -1};
`ifdef LFSR_CHECKER_FLYWHEEL_EN
    pl = '{200, -1, -1, -1, -1};
    run_stream(300, 0, 1'b0, fl, pl, 100000, 100000);
    chk("flip200_err_count", 1, {16'd0, err_count}, 1);
`else
    // Errors at 200 and when the flip reaches taps 0,3,5: fourth error drops lock, relock 62 bits later.
    pl = '{200, 201, 204, 206, -1};
    run_stream(300, 0, 1'b0, fl, pl, 206, 268);
    chk("flip200_err_count", 1, {16'd0, err_count}, 4);
`endif

    // Reset while locked clears everything on the next edge.
    do_reset();
    @(negedge clk);
    chk("midlock_rst_locked", 2, {31'd0, locked}, 0);
    chk("midlock_rst_err_count", 2, {16'd0, err_count}, 0);
    chk("midlock_rst_err_pulse", 2, {31'd0, err_pulse}, 0);

    // Flip at 249: tap echo at 253 lands on the window wrap bit and opens a fresh window.
    fl = '{249, -1, -1, -1, -1};
`ifdef LFSR_CHECKER_FLYWHEEL_EN
    pl = '{249, -1, -1, -1, -1};
    run_stream(300, 0, 1'b0, fl, pl, 100000, 100000);
    chk("wrap_err_count", 3, {16'd0, err_count}, 1);
`else
    pl = '{249, 250, 253, 255, 279};
    run_stream(300, 0, 1'b0, fl, pl, 100000, 100000);
    chk("wrap_err_count", 3, {16'd0, err_count}, 5);
`endif

    // All-zero stream never locks.
    do_reset();
    run_stream(500, 0, 1'b1, none, none, 100000, 100000);
    chk("zeros_err_count", 4, {16'd0, err_count}, 0);

    // Gapped valid (1 in 3), error counter preloaded just under saturation.
    do_reset();
    force dut.err_count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.err_count_q;
`ifdef LFSR_CHECKER_FLYWHEEL_EN
    fl = '{150, 170, -1, -1, -1};
    pl = '{150, 170, -1, -1, -1};
    run_stream(250, 2, 1'b0, fl, pl, 100000, 100000);
`else
    fl = '{150, -1, -1, -1, -1};
    pl = '{150, 151, 154, 156, -1};
    run_stream(250, 2, 1'b0, fl, pl, 156, 218);
`endif
    chk("sat_err_count", 5, {16'd0, err_count}, 32'h0000FFFF);

    // Long clean run: lock at bit 61 and no errors.
    do_reset();
    run_stream(10000, 0, 1'b0, none, none, 100000, 100000);
    chk("clean_err_count", 6, {16'd0, err_count}, 0);
    chk("clean_locked_end", 6, {31'd0, locked}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
